// File: rtl/median_pkg.sv
// Shared types and defaults for the median filter and its window generator:
// pixel type, pixel index width, default image geometry and generator FSM states.
package median_pkg;

    typedef logic [7:0] pixel_t;

    localparam int PIX_IDX_W   = 32;
    localparam int NUM_TAPS    = 9;
    localparam int DEFAULT_ROW = 430;
    localparam int DEFAULT_COL = 554;

    typedef enum logic [1:0] {
        WG_IDLE,
        WG_FILL,
        WG_STREAM,
        WG_FLUSH
    } wingen_state_t;

endpackage

// File: rtl/column_delay.sv
// Fixed-length pixel delay line between the 3-sample shift stages of the
// window generator. Advances only when en is high, so stalls freeze it.
// Deep lines use a circular buffer with a single read/write pointer; a
// one-deep line is a plain register. Pixel storage is never reset.
module column_delay
    import median_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  pixel_t din,
    output pixel_t dout
);

    generate
        if (DEPTH == 1) begin : g_single
            pixel_t hold_q;
            logic   unused_rst_n;

            assign unused_rst_n = rst_n;

            // One-sample delay: capture the incoming pixel on every advance
            always_ff @(posedge clk) begin
                if (en) begin
                    hold_q <= din;
                end
            end

            assign dout = hold_q;
        end else begin : g_ring
            localparam int PW = $clog2(DEPTH);

            pixel_t        mem [DEPTH];
            logic [PW-1:0] ptr_q;

            // Pointer walks the ring; the slot it names holds the oldest sample
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ptr_q <= '0;
                end else if (en) begin
                    if (ptr_q == PW'(DEPTH - 1)) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= ptr_q + 1'b1;
                    end
                end
            end

            // Overwrite the oldest sample with the newest one as it is read out
            always_ff @(posedge clk) begin
                if (en) begin
                    mem[ptr_q] <= din;
                end
            end

            assign dout = mem[ptr_q];
        end
    endgenerate

endmodule

// File: rtl/median_window_gen.sv
// Streaming 3x3 window generator feeding the median filter. Pixels arrive in
// column-major order (ROW per column); a delay chain of 2*ROW+3 samples holds
// the neighbourhood, and one registered window is produced per accepted pixel
// once the chain is primed, followed by ROW+1 self-driven flush windows.
// Optional build macro MEDIAN_WINGEN_ZERO_PAD_EN forces taps that fall outside
// the image to zero; without it those taps carry whatever the chain holds.
module median_window_gen
    import median_pkg::*;
#(
    parameter int ROW = DEFAULT_ROW,
    parameter int COL = DEFAULT_COL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               win_valid,
    output logic [7:0]         win_0,
    output logic [7:0]         win_1,
    output logic [7:0]         win_2,
    output logic [7:0]         win_3,
    output logic [7:0]         win_4,
    output logic [7:0]         win_5,
    output logic [7:0]         win_6,
    output logic [7:0]         win_7,
    output logic [7:0]         win_8,
    output logic signed [31:0] pixel,
    output logic               frame_done
);

    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);

    localparam logic [PIX_IDX_W-1:0] FIRST_EMIT_IDX = PIX_IDX_W'(ROW + 1);
    localparam logic [PIX_IDX_W-1:0] LAST_IDX       = PIX_IDX_W'(ROW * COL - 1);
    localparam logic [RW-1:0]        LAST_R         = RW'(ROW - 1);
    localparam logic [CW-1:0]        LAST_C         = CW'(COL - 1);

    wingen_state_t        state_q;
    logic [PIX_IDX_W-1:0] q_cnt;
    logic [PIX_IDX_W-1:0] p_cnt;
    logic [RW-1:0]        r_cnt;
    logic [CW-1:0]        c_cnt;

    pixel_t stage_a [3];
    pixel_t stage_b [3];
    pixel_t stage_c [2];
    pixel_t next_a  [3];
    pixel_t next_b  [3];
    pixel_t next_c  [3];
    pixel_t col0_tail;
    pixel_t col1_tail;

    pixel_t tap_next [NUM_TAPS];
    pixel_t win_q    [NUM_TAPS];

    logic   accept;
    logic   flushing;
    logic   shift_en;
    logic   emit;
    logic   last_window;
    pixel_t shift_in;

    assign accept      = in_valid & in_ready;
    assign flushing    = (state_q == WG_FLUSH);
    assign shift_en    = accept | flushing;
    assign shift_in    = flushing ? '0 : in_data;
    assign emit        = flushing
                       | (accept & ((state_q == WG_STREAM)
                                  | ((state_q == WG_FILL) & (q_cnt == FIRST_EMIT_IDX))));
    assign last_window = flushing & (p_cnt == LAST_IDX);

    // Chain positions 3..ROW-1 and ROW+3..2*ROW-1 live in the two delay lines
    column_delay #(
        .DEPTH (ROW - 3)
    ) u_col0 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .din   (stage_a[2]),
        .dout  (col0_tail)
    );

    column_delay #(
        .DEPTH (ROW - 3)
    ) u_col1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .din   (stage_b[2]),
        .dout  (col1_tail)
    );

    // Post-shift view of the three tap stages; the oldest slot of the last
    // stage is the previous second slot, so it never needs its own register
    always_comb begin
        next_a[0] = shift_in;
        next_a[1] = stage_a[0];
        next_a[2] = stage_a[1];
        next_b[0] = col0_tail;
        next_b[1] = stage_b[0];
        next_b[2] = stage_b[1];
        next_c[0] = col1_tail;
        next_c[1] = stage_c[0];
        next_c[2] = stage_c[1];
    end

`ifdef MEDIAN_WINGEN_ZERO_PAD_EN
    logic pad_row_lo;
    logic pad_row_hi;
    logic pad_col_lo;
    logic pad_col_hi;

    assign pad_row_lo = (r_cnt == '0);
    assign pad_row_hi = (r_cnt == LAST_R);
    assign pad_col_lo = (c_cnt == '0);
    assign pad_col_hi = (c_cnt == LAST_C);
`endif

    // Map chain slots to taps: j picks the column stage, k the row within it
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            tap_next[3*k + 0] = next_c[2 - k];
            tap_next[3*k + 1] = next_b[2 - k];
            tap_next[3*k + 2] = next_a[2 - k];
        end
`ifdef MEDIAN_WINGEN_ZERO_PAD_EN
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                if ((k == 0 && pad_row_lo) || (k == 2 && pad_row_hi) ||
                    (j == 0 && pad_col_lo) || (j == 2 && pad_col_hi)) begin
                    tap_next[3*k + j] = '0;
                end
            end
        end
`endif
    end

    // Delay chain shift stages; storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (shift_en) begin
            stage_a    <= next_a;
            stage_b    <= next_b;
            stage_c[0] <= next_c[0];
            stage_c[1] <= next_c[1];
        end
    end

    // Frame sequencing, position counters and the registered window outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WG_IDLE;
            q_cnt      <= '0;
            p_cnt      <= '0;
            r_cnt      <= '0;
            c_cnt      <= '0;
            in_ready   <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            pixel      <= '0;
            win_q      <= '{default: '0};
        end else begin
            in_ready   <= 1'b1;
            win_valid  <= emit;
            frame_done <= last_window;

            case (state_q)
                WG_IDLE: begin
                    if (accept) begin
                        q_cnt   <= PIX_IDX_W'(1);
                        state_q <= WG_FILL;
                    end
                end
                WG_FILL: begin
                    if (accept) begin
                        q_cnt <= q_cnt + 1'b1;
                        if (q_cnt == FIRST_EMIT_IDX) begin
                            state_q <= WG_STREAM;
                        end
                    end
                end
                WG_STREAM: begin
                    if (accept) begin
                        q_cnt <= q_cnt + 1'b1;
                        if (q_cnt == LAST_IDX) begin
                            state_q  <= WG_FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                WG_FLUSH: begin
                    if (last_window) begin
                        state_q <= WG_IDLE;
                        q_cnt   <= '0;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state_q <= WG_IDLE;
                end
            endcase

            if (emit) begin
                win_q <= tap_next;
                pixel <= signed'(p_cnt);
                if (last_window) begin
                    p_cnt <= '0;
                end else begin
                    p_cnt <= p_cnt + 1'b1;
                end
                if (r_cnt == LAST_R) begin
                    r_cnt <= '0;
                    if (c_cnt == LAST_C) begin
                        c_cnt <= '0;
                    end else begin
                        c_cnt <= c_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign win_0 = win_q[0];
    assign win_1 = win_q[1];
    assign win_2 = win_q[2];
    assign win_3 = win_q[3];
    assign win_4 = win_q[4];
    assign win_5 = win_q[5];
    assign win_6 = win_q[6];
    assign win_7 = win_q[7];
    assign win_8 = win_q[8];

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on a 4x3 image with in_data = q + offset.
// Expected taps come from image coordinates: tap (k,j) of centre p sits at
// row r+k-1, column c+j-1, whose sample index is column*ROW + row.
module tb_median_window_gen;

    localparam int ROW  = 4;
    localparam int COL  = 3;
    localparam int NPIX = ROW * COL;
    localparam int LAT  = ROW + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [7:0]         in_data;
    logic               in_ready;
    logic               win_valid;
    logic [7:0]         win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
    logic signed [31:0] pixel;
    logic               frame_done;
    logic [7:0]         taps [9];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    median_window_gen #(.ROW(ROW), .COL(COL)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .win_valid(win_valid),
        .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
        .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
        .pixel(pixel), .frame_done(frame_done)
    );

    assign taps[0] = win_0;
    assign taps[1] = win_1;
    assign taps[2] = win_2;
    assign taps[3] = win_3;
    assign taps[4] = win_4;
    assign taps[5] = win_5;
    assign taps[6] = win_6;
    assign taps[7] = win_7;
    assign taps[8] = win_8;

    // Expected tap value, or -1 where the tap is outside the image and unpadded
    function automatic int exp_tap(input int p, input int t, input int off);
        int rr;
        int cc;
        rr = (p % ROW) + (t / 3) - 1;
        cc = (p / ROW) + (t % 3) - 1;
        if (rr < 0 || rr >= ROW || cc < 0 || cc >= COL) begin
`ifdef MEDIAN_WINGEN_ZERO_PAD_EN
            return 0;
`else
            return -1;
`endif
        end
        return cc * ROW + rr + off;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        step(); step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_ready: got %b expected 0", in_ready); end
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_valid: got %b expected 0", win_valid); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done: got %b expected 0", frame_done); end
        n_cmp++; if (pixel !== 32'sd0) begin n_fail++; $display("[TB] FAIL rst_pixel: got %0d expected 0", pixel); end
        for (int t = 0; t < 9; t++) begin
            n_cmp++; if (taps[t] !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_win_%0d: got %0d expected 0", t, taps[t]); end
        end
        #2 rst_n = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_release_ready: got %b expected 1", in_ready); end
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_release_valid: got %b expected 0", win_valid); end
    endtask

    task automatic test_stream();
        int e;
        int p;
        int hv_mid [9] = '{0, 4, 8, 1, 5, 9, 2, 6, 10};
`ifdef MEDIAN_WINGEN_ZERO_PAD_EN
        int hv_p0  [9] = '{0, 0, 0, 0, 0, 4, 0, 1, 5};
        int hv_p11 [9] = '{6, 10, 0, 7, 11, 0, 0, 0, 0};
`endif
        $display("[TB] continuous frame");
        for (int q = 0; q < NPIX; q++) begin
            in_valid = 1'b1; in_data = 8'(q);
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL stream_ready q=%0d: got %b expected 1", q, in_ready); end
            step();
            n_cmp++; if (win_valid !== (q >= LAT)) begin n_fail++; $display("[TB] FAIL stream_valid q=%0d: got %b expected %b", q, win_valid, q >= LAT); end
            n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_done q=%0d: got %b expected 0", q, frame_done); end
            if (q >= LAT) begin
                p = q - LAT;
                n_cmp++; if (pixel !== p) begin n_fail++; $display("[TB] FAIL stream_pixel q=%0d: got %0d expected %0d", q, pixel, p); end
                for (int t = 0; t < 9; t++) begin
                    e = exp_tap(p, t, 0);
                    if (e >= 0) begin
                        n_cmp++; if (taps[t] !== 8'(e)) begin n_fail++; $display("[TB] FAIL stream_win_%0d p=%0d: got %0d expected %0d", t, p, taps[t], e); end
                    end
                    if (p == 5) begin
                        n_cmp++; if (taps[t] !== 8'(hv_mid[t])) begin n_fail++; $display("[TB] FAIL interior_win_%0d: got %0d expected %0d", t, taps[t], hv_mid[t]); end
                    end
`ifdef MEDIAN_WINGEN_ZERO_PAD_EN
                    if (p == 0) begin
                        n_cmp++; if (taps[t] !== 8'(hv_p0[t])) begin n_fail++; $display("[TB] FAIL pad_p0_win_%0d: got %0d expected %0d", t, taps[t], hv_p0[t]); end
                    end
`endif
                end
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < ROW + 1; i++) begin
            p = NPIX - ROW - 1 + i;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ready i=%0d: got %b expected 0", i, in_ready); end
            step();
            n_cmp++; if (win_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_valid i=%0d: got %b expected 1", i, win_valid); end
            n_cmp++; if (pixel !== p) begin n_fail++; $display("[TB] FAIL flush_pixel i=%0d: got %0d expected %0d", i, pixel, p); end
            n_cmp++; if (frame_done !== (i == ROW)) begin n_fail++; $display("[TB] FAIL flush_done i=%0d: got %b expected %b", i, frame_done, i == ROW); end
            for (int t = 0; t < 9; t++) begin
                e = exp_tap(p, t, 0);
                if (e >= 0) begin
                    n_cmp++; if (taps[t] !== 8'(e)) begin n_fail++; $display("[TB] FAIL flush_win_%0d p=%0d: got %0d expected %0d", t, p, taps[t], e); end
                end
`ifdef MEDIAN_WINGEN_ZERO_PAD_EN
                if (p == NPIX - 1) begin
                    n_cmp++; if (taps[t] !== 8'(hv_p11[t])) begin n_fail++; $display("[TB] FAIL pad_p11_win_%0d: got %0d expected %0d", t, taps[t], hv_p11[t]); end
                end
`endif
            end
        end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_ready: got %b expected 1", in_ready); end
        step();
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_valid: got %b expected 0", win_valid); end
    endtask

    task automatic test_stall();
        int e;
        int p;
        $display("[TB] frame with input gap at q=7");
        for (int q = 0; q < NPIX; q++) begin
            if (q == 7) begin
                in_valid = 1'b0; in_data = 8'hEE;
                for (int g = 0; g < 3; g++) begin
                    step();
                    n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_valid g=%0d: got %b expected 0", g, win_valid); end
                    n_cmp++; if (pixel !== 32'sd1) begin n_fail++; $display("[TB] FAIL stall_pixel g=%0d: got %0d expected 1", g, pixel); end
                end
            end
            in_valid = 1'b1; in_data = 8'(q);
            step();
            n_cmp++; if (win_valid !== (q >= LAT)) begin n_fail++; $display("[TB] FAIL stall_run_valid q=%0d: got %b expected %b", q, win_valid, q >= LAT); end
            if (q >= LAT) begin
                p = q - LAT;
                n_cmp++; if (pixel !== p) begin n_fail++; $display("[TB] FAIL stall_run_pixel q=%0d: got %0d expected %0d", q, pixel, p); end
                for (int t = 0; t < 9; t++) begin
                    e = exp_tap(p, t, 0);
                    if (e >= 0) begin
                        n_cmp++; if (taps[t] !== 8'(e)) begin n_fail++; $display("[TB] FAIL stall_win_%0d p=%0d: got %0d expected %0d", t, p, taps[t], e); end
                    end
                end
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < ROW + 1; i++) begin
            step();
            n_cmp++; if (pixel !== NPIX - ROW - 1 + i) begin n_fail++; $display("[TB] FAIL stall_flush_pixel i=%0d: got %0d expected %0d", i, pixel, NPIX - ROW - 1 + i); end
        end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_done: got %b expected 1", frame_done); end
    endtask

    task automatic test_reset_mid();
        int e;
        int p;
        $display("[TB] reset mid-frame then fresh frame");
        for (int q = 0; q < 8; q++) begin
            in_valid = 1'b1; in_data = 8'(q);
            step();
        end
        in_data = 8'd8;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b expected 0", in_ready); end
        n_cmp++; if (win_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valid: got %b expected 0", win_valid); end
        n_cmp++; if (pixel !== 32'sd0) begin n_fail++; $display("[TB] FAIL midrst_pixel: got %0d expected 0", pixel); end
        n_cmp++; if (win_4 !== 8'd0) begin n_fail++; $display("[TB] FAIL midrst_win_4: got %0d expected 0", win_4); end
        in_valid = 1'b0;
        step(); step();
        #2 rst_n = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_release_ready: got %b expected 1", in_ready); end
        for (int q = 0; q < NPIX; q++) begin
            in_valid = 1'b1; in_data = 8'(q + 100);
            step();
            n_cmp++; if (win_valid !== (q >= LAT)) begin n_fail++; $display("[TB] FAIL fresh_valid q=%0d: got %b expected %b", q, win_valid, q >= LAT); end
            if (q >= LAT) begin
                p = q - LAT;
                n_cmp++; if (pixel !== p) begin n_fail++; $display("[TB] FAIL fresh_pixel q=%0d: got %0d expected %0d", q, pixel, p); end
                for (int t = 0; t < 9; t++) begin
                    e = exp_tap(p, t, 100);
                    if (e >= 0) begin
                        n_cmp++; if (taps[t] !== 8'(e)) begin n_fail++; $display("[TB] FAIL fresh_win_%0d p=%0d: got %0d expected %0d", t, p, taps[t], e); end
                    end
                end
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < ROW + 1; i++) begin
            step();
        end
        n_cmp++; if (frame_done !== 1'b1 || pixel !== NPIX - 1) begin n_fail++; $display("[TB] FAIL fresh_done: got done=%b pixel=%0d expected done=1 pixel=%0d", frame_done, pixel, NPIX - 1); end
    endtask

    task automatic test_back_to_back();
        int  acc_q = 0, frame = 0, exp_p = 0, wframe = 0, cyc = 0, done_frames = 0, flush_cnt = 0;
        int  acc_idx, e;
        bit  acc, rdy_before, e_valid, expect_start = 1'b0;
        $display("[TB] back-to-back frames");
        in_valid = 1'b1;
        while (done_frames < 2 && cyc < 200) begin
            in_data    = 8'(acc_q + ((frame == 0) ? 0 : 50));
            rdy_before = in_ready;
            acc        = in_valid && in_ready;
            acc_idx    = acc_q;
            if (expect_start) begin
                expect_start = 1'b0;
                n_cmp++; if (!(acc && acc_idx == 0 && frame == 1)) begin n_fail++; $display("[TB] FAIL b2b_restart: got accept=%b q=%0d expected accept=1 q=0", acc, acc_idx); end
            end
            step();
            cyc++;
            if (!rdy_before) flush_cnt++;
            if (acc) begin
                acc_q++;
                if (acc_q == NPIX) begin acc_q = 0; frame++; end
            end
            e_valid = acc ? (acc_idx >= LAT) : !rdy_before;
            n_cmp++; if (win_valid !== e_valid) begin n_fail++; $display("[TB] FAIL b2b_valid cyc=%0d: got %b expected %b", cyc, win_valid, e_valid); end
            if (e_valid) begin
                n_cmp++; if (pixel !== exp_p) begin n_fail++; $display("[TB] FAIL b2b_pixel cyc=%0d: got %0d expected %0d", cyc, pixel, exp_p); end
                n_cmp++; if (frame_done !== (exp_p == NPIX - 1)) begin n_fail++; $display("[TB] FAIL b2b_done p=%0d: got %b expected %b", exp_p, frame_done, exp_p == NPIX - 1); end
                for (int t = 0; t < 9; t++) begin
                    e = exp_tap(exp_p, t, (wframe == 0) ? 0 : 50);
                    if (e >= 0) begin
                        n_cmp++; if (taps[t] !== 8'(e)) begin n_fail++; $display("[TB] FAIL b2b_win_%0d p=%0d: got %0d expected %0d", t, exp_p, taps[t], e); end
                    end
                end
                if (exp_p == NPIX - 1) begin
                    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_ready_at_done: got %b expected 1", in_ready); end
                    done_frames++; wframe++; exp_p = 0;
                    if (done_frames == 1) expect_start = 1'b1;
                end else begin
                    exp_p++;
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++; if (cyc >= 200) begin n_fail++; $display("[TB] FAIL b2b_timeout: got %0d frames expected 2", done_frames); end
        n_cmp++; if (flush_cnt !== 2 * (ROW + 1)) begin n_fail++; $display("[TB] FAIL b2b_flush_cycles: got %0d expected %0d", flush_cnt, 2 * (ROW + 1)); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
